alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_addsub.sv | 38 +++
 rtl/alu.sv | 84 ++++++++
 tb/tb_alu.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// alu_pkg : opcodes and flag bundle shared by the ALU and its add/sub datapath
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic zero;
        logic negative;
    } alu_flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_addsub.sv
//------------------------------------------------------------------------------
// alu_addsub : combinational WIDTH+1-bit adder/subtractor with carry and overflow
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    // Subtraction folds into the adder as A + ~B + 1, so carry is not-borrow.
    always_comb begin
        w_sub   = (op_i == ALU_SUB);
        w_b_eff = w_sub ? ~b_i : b_i;
        w_sum   = {1'b0, a_i} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    end

    assign sum_o      = w_sum[WIDTH-1:0];
    assign carry_o    = w_sum[WIDTH];
    assign overflow_o = (a_i[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != a_i[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/alu.sv
//------------------------------------------------------------------------------
// alu : registered signed ADD/SUB with optional saturation and status flags
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu
    import alu_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int SATURATE   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ALU_operation,
    input  logic signed [WORD_WIDTH-1:0] A,
    input  logic signed [WORD_WIDTH-1:0] B,
    input  logic                         in_valid,
    output logic signed [WORD_WIDTH-1:0] AlU_out,
    output logic                         out_valid,
    output logic                         overflow,
    output logic                         carry,
    output logic                         zero,
    output logic                         negative
);

    localparam logic [WORD_WIDTH-1:0] c_sat_max = {1'b0, {(WORD_WIDTH-1){1'b1}}};
    localparam logic [WORD_WIDTH-1:0] c_sat_min = {1'b1, {(WORD_WIDTH-1){1'b0}}};

    logic [WORD_WIDTH-1:0] w_sum;
    logic                  w_carry;
    logic                  w_overflow;

    logic [WORD_WIDTH-1:0] result_d, result_q;
    alu_flags_t            flags_d, flags_q;
    logic                  out_valid_q;

    alu_addsub #(
        .WIDTH(WORD_WIDTH)
    ) u_addsub (
        .a_i       (A),
        .b_i       (B),
        .op_i      (ALU_operation),
        .sum_o     (w_sum),
        .carry_o   (w_carry),
        .overflow_o(w_overflow)
    );

    // Clamp direction follows A: an overflow can only go past the end A sits on.
    always_comb begin
        result_d = w_sum;
        if ((SATURATE != 0) && w_overflow) begin
            result_d = A[WORD_WIDTH-1] ? c_sat_min : c_sat_max;
        end
        flags_d.overflow = w_overflow;
        flags_d.carry    = w_carry;
        flags_d.zero     = (result_d == '0);
        flags_d.negative = result_d[WORD_WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            flags_q     <= '{overflow: 1'b0, carry: 1'b0, zero: 1'b1, negative: 1'b0};
            out_valid_q <= 1'b0;
        end else if (in_valid) begin
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign AlU_out   = result_q;
    assign out_valid = out_valid_q;
    assign overflow  = flags_q.overflow;
    assign carry     = flags_q.carry;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
//------------------------------------------------------------------------------
// tb_alu : scoreboard bench driving a wrapping and a saturating ALU in lockstep
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ov;
        logic         cy;
        logic         z;
        logic         n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         op;
    logic [W-1:0] a, b;
    logic         in_valid;

    logic [W-1:0] res0, res1;
    logic         vld0, ov0, cy0, z0, n0;
    logic         vld1, ov1, cy1, z1, n1;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last0, last1;

    always #5 clk = ~clk;

    alu #(.WORD_WIDTH(W), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .ALU_operation(op), .A(a), .B(b), .in_valid(in_valid),
        .AlU_out(res0), .out_valid(vld0), .overflow(ov0), .carry(cy0), .zero(z0), .negative(n0)
    );

    alu #(.WORD_WIDTH(W), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .ALU_operation(op), .A(a), .B(b), .in_valid(in_valid),
        .AlU_out(res1), .out_valid(vld1), .overflow(ov1), .carry(cy1), .zero(z1), .negative(n1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model on wide signed integers, independent of the adder structure.
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input bit sat);
        exp_t   e;
        longint sx, sy, t, ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        t  = o ? (sx - sy) : (sx + sy);
        e.ov  = (t > 32767) || (t < -32768);
        e.cy  = o ? (ux >= uy) : ((ux + uy) > 65535);
        e.res = t[W-1:0];
        if (sat && e.ov) e.res = (sx >= 0) ? 16'h7fff : 16'h8000;
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    task automatic cmp(input string p, input logic [W-1:0] r, input logic ov, input logic cy,
                       input logic z, input logic n, input exp_t e);
        chk({p, ".AlU_out"},  64'(r),  64'(e.res));
        chk({p, ".overflow"}, 64'(ov), 64'(e.ov));
        chk({p, ".carry"},    64'(cy), 64'(e.cy));
        chk({p, ".zero"},     64'(z),  64'(e.z));
        chk({p, ".negative"}, 64'(n),  64'(e.n));
    endtask

    // Drive at negedge, let the DUT capture at posedge, check #1 later.
    task automatic step(input logic r, input logic v, input logic o, input int x, input int y);
        logic [W-1:0] xa, yb;
        exp_t rst_e;
        xa = x[W-1:0];
        yb = y[W-1:0];
        rst = r; in_valid = v; op = o; a = xa; b = yb;
        if (!r && v) begin
            q0.push_back(model(o, xa, yb, 1'b0));
            q1.push_back(model(o, xa, yb, 1'b1));
        end
        @(posedge clk);
        #1;
        if (r) begin
            rst_e = '{res: '0, ov: 1'b0, cy: 1'b0, z: 1'b1, n: 1'b0};
            q0.delete(); q1.delete();
            last0 = rst_e; last1 = rst_e;
        end
        chk("wrap.out_valid", 64'(vld0), 64'(v && !r));
        chk("sat.out_valid",  64'(vld1), 64'(v && !r));
        if (vld0) begin
            if (q0.size() == 0) chk("wrap.scoreboard_empty", 64'(1), 64'(0));
            else last0 = q0.pop_front();
        end
        if (vld1) begin
            if (q1.size() == 0) chk("sat.scoreboard_empty", 64'(1), 64'(0));
            else last1 = q1.pop_front();
        end
        cmp("wrap", res0, ov0, cy0, z0, n0, last0);
        cmp("sat",  res1, ov1, cy1, z1, n1, last1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0;
        last0 = '0; last1 = '0;
        @(negedge clk);
        // Reset wins over a simultaneous valid operation.
        step(1'b1, 1'b1, 1'b0, 1, 1);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        // Directed cases, back-to-back.
        step(1'b0, 1'b1, 1'b1, 15, 4);
        step(1'b0, 1'b1, 1'b0, 487, 49);
        step(1'b0, 1'b1, 1'b0, 32767, 1);
        step(1'b0, 1'b1, 1'b1, -32768, 1);
        step(1'b0, 1'b1, 1'b1, 5, 5);
        step(1'b0, 1'b1, 1'b1, 0, 0);
        step(1'b0, 1'b1, 1'b0, -32768, -1);
        step(1'b0, 1'b1, 1'b1, 32767, -1);
        step(1'b0, 1'b1, 1'b0, -1, 1);
        // Idle: outputs must hold the last result.
        step(1'b0, 1'b0, 1'b0, 123, 456);
        step(1'b0, 1'b0, 1'b1, 7, 9);
        // Four back-to-back, then idle.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i[0], 1000 * i - 1500, 300 + i);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        // Random traffic with occasional bubbles.
        for (int i = 0; i < 40; i++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        end
        // Mid-stream reset, then first op after reset.
        step(1'b1, 1'b1, 1'b0, 100, 200);
        step(1'b0, 1'b1, 1'b1, 3, 10);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
